// File: rtl/seg_sequence_checker.sv
// Loop-back checker: decodes strobed seven-segment patterns and checks them against
// the fixed 14-glyph frame, reporting per-character decode, frame lock and saturating counts.
module seg_sequence_checker #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seg_strobe,
   input  logic [7:0]       seg_in,
   input  logic             clear,
   output logic [3:0]       char_code,
   output logic             char_valid,
   output logic [3:0]       pos,
   output logic             locked,
   output logic             frame_done,
   output logic [CNT_W-1:0] match_count,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {S_HUNT, S_TRACK, S_LOCKED} state_t;

   localparam logic [3:0] LAST_POS = 4'd13;
   localparam logic [3:0] UNKNOWN  = 4'hF;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_edge;
   logic [7:0]             r_seg;
   state_t                 r_state;

   logic                   w_rise;
   logic [3:0]             w_code;
   logic [3:0]             w_expected;
   state_t                 w_state_nx;
   logic [3:0]             w_pos_nx;
   logic                   w_inc_match;
   logic                   w_inc_err;
   logic                   w_frame_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
         r_edge <= 1'b0;
         r_seg  <= 8'h00;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], seg_strobe};
         r_edge <= r_sync[SYNC_STAGES-1];
         r_seg  <= seg_in;
      end
   end

   assign w_rise = r_sync[SYNC_STAGES-1] & ~r_edge;

   // Any pattern with dp set falls through to the unknown glyph.
   always_comb begin
      w_code = UNKNOWN;
      case (r_seg)
         8'h5B:   w_code = 4'd0;
         8'h4F:   w_code = 4'd1;
         8'h15:   w_code = 4'd2;
         8'h7E:   w_code = 4'd3;
         8'h0E:   w_code = 4'd4;
         8'h5F:   w_code = 4'd5;
         8'h3E:   w_code = 4'd6;
         8'h00:   w_code = 4'd7;
         default: w_code = UNKNOWN;
      endcase
   end

   // Frame S E n O L G U L G O n U L blank.
   always_comb begin
      w_expected = 4'd7;
      case (pos)
         4'd0:    w_expected = 4'd0;
         4'd1:    w_expected = 4'd1;
         4'd2:    w_expected = 4'd2;
         4'd3:    w_expected = 4'd3;
         4'd4:    w_expected = 4'd4;
         4'd5:    w_expected = 4'd5;
         4'd6:    w_expected = 4'd6;
         4'd7:    w_expected = 4'd4;
         4'd8:    w_expected = 4'd5;
         4'd9:    w_expected = 4'd3;
         4'd10:   w_expected = 4'd2;
         4'd11:   w_expected = 4'd6;
         4'd12:   w_expected = 4'd4;
         default: w_expected = 4'd7;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_HUNT;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_pos_nx     = pos;
      w_inc_match  = 1'b0;
      w_inc_err    = 1'b0;
      w_frame_done = 1'b0;
      if (w_rise) begin
         case (r_state)
            S_HUNT: begin
               if (w_code == 4'd0) begin
                  w_state_nx  = S_TRACK;
                  w_pos_nx    = 4'd1;
                  w_inc_match = 1'b1;
               end
            end
            S_TRACK, S_LOCKED: begin
               if (w_code == w_expected) begin
                  w_inc_match = 1'b1;
                  if (pos == LAST_POS) begin
                     w_frame_done = 1'b1;
                     w_state_nx   = S_LOCKED;
                     w_pos_nx     = 4'd0;
                  end else begin
                     w_pos_nx = pos + 4'd1;
                  end
               end else begin
                  // A stray S is taken as the start of a fresh frame.
                  w_inc_err = 1'b1;
                  if (w_code == 4'd0) begin
                     w_state_nx  = S_TRACK;
                     w_pos_nx    = 4'd1;
                     w_inc_match = 1'b1;
                  end else begin
                     w_state_nx = S_HUNT;
                     w_pos_nx   = 4'd0;
                  end
               end
            end
            default: begin
               w_state_nx = S_HUNT;
               w_pos_nx   = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         char_code   <= 4'd0;
         char_valid  <= 1'b0;
         pos         <= 4'd0;
         locked      <= 1'b0;
         frame_done  <= 1'b0;
         match_count <= '0;
         err_count   <= '0;
      end else begin
         char_valid <= w_rise;
         frame_done <= w_frame_done;
         pos        <= w_pos_nx;
         locked     <= (w_state_nx == S_LOCKED);
         if (w_rise) begin
            char_code <= w_code;
         end
         // Clear has priority over a same-cycle count event.
         if (clear) begin
            match_count <= '0;
            err_count   <= '0;
         end else begin
            if (w_inc_match && !(&match_count)) begin
               match_count <= match_count + 1'b1;
            end
            if (w_inc_err && !(&err_count)) begin
               err_count <= err_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_sequence_checker.sv
// Randomized scoreboard bench for seg_sequence_checker against a rule-level frame model.
module tb_seg_sequence_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       seg_strobe;
   logic [7:0] seg_in;
   logic       clear;
   logic [3:0] char_code;
   logic       char_valid;
   logic [3:0] pos;
   logic       locked;
   logic       frame_done;
   logic [7:0] match_count;
   logic [7:0] err_count;

   seg_sequence_checker #(.SYNC_STAGES(2), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_strobe  (seg_strobe),
      .seg_in      (seg_in),
      .clear       (clear),
      .char_code   (char_code),
      .char_valid  (char_valid),
      .pos         (pos),
      .locked      (locked),
      .frame_done  (frame_done),
      .match_count (match_count),
      .err_count   (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int code;
      int pos;
      int locked;
      int fd;
      int mc;
      int ec;
      int cyc;
   } exp_t;

   exp_t exp_q[$];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;

   logic [7:0] PATS  [8]  = '{8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F, 8'h3E, 8'h00};
   int         FRAME [14] = '{0, 1, 2, 3, 4, 5, 6, 4, 5, 3, 2, 6, 4, 7};

   // Model: mode 0 = hunting, 1 = tracking, 2 = locked.
   int m_mode, m_pos, m_mc, m_ec;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int expv);
      n_chk++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic int decode(input logic [7:0] p);
      for (int i = 0; i < 8; i++) if (PATS[i] == p) return i;
      return 15;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pos = 0; m_mc = 0; m_ec = 0;
   endtask

   task automatic model_step(input logic [7:0] p, input bit clr, output exp_t e);
      int code;
      int fd;
      code = decode(p);
      fd = 0;
      if (m_mode == 0) begin
         if (code == 0) begin m_mode = 1; m_pos = 1; m_mc++; end
      end else if (code == FRAME[m_pos]) begin
         m_mc++;
         if (m_pos == 13) begin fd = 1; m_mode = 2; m_pos = 0; end
         else m_pos++;
      end else begin
         m_ec++;
         if (code == 0) begin m_mode = 1; m_pos = 1; m_mc++; end
         else begin m_mode = 0; m_pos = 0; end
      end
      if (m_mc > 255) m_mc = 255;
      if (m_ec > 255) m_ec = 255;
      if (clr) begin m_mc = 0; m_ec = 0; end
      e.code = code; e.pos = m_pos; e.locked = (m_mode == 2) ? 1 : 0;
      e.fd = fd; e.mc = m_mc; e.ec = m_ec; e.cyc = 0;
   endtask

   // Called at a negedge; strobe is first sampled at the next posedge, results two edges later.
   task automatic send(input logic [7:0] p, input bit clr);
      exp_t e;
      model_step(p, clr, e);
      e.cyc = cyc + 3;
      exp_q.push_back(e);
      seg_in     = p;
      seg_strobe = 1'b1;
      repeat (2) @(negedge clk);
      if (clr) clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
      seg_strobe = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string tag, input int c_pos, input int c_lock,
                                     input int c_mc, input int c_ec);
      chk({tag, "_pos"}, int'(pos), c_pos);
      chk({tag, "_locked"}, int'(locked), c_lock);
      chk({tag, "_match"}, int'(match_count), c_mc);
      chk({tag, "_err"}, int'(err_count), c_ec);
   endtask

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (char_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_char_valid", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("latency_cycle", cyc, e.cyc);
               chk("char_code", int'(char_code), e.code);
               chk("pos", int'(pos), e.pos);
               chk("locked", int'(locked), e.locked);
               chk("frame_done", int'(frame_done), e.fd);
               chk("match_count", int'(match_count), e.mc);
               chk("err_count", int'(err_count), e.ec);
            end
         end else if (frame_done) begin
            chk("frame_done_without_char", 1, 0);
         end
      end
   end

   initial begin
      int r;
      rst = 1'b0; seg_strobe = 1'b0; seg_in = 8'h00; clear = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_char_code", int'(char_code), 0);
      chk("rst_char_valid", int'(char_valid), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      check_idle_outputs("rst", 0, 0, 0, 0);
      mon_en = 1'b1;
      repeat (20) @(negedge clk);

      // Full frame.
      for (int i = 0; i < 14; i++) send(PATS[FRAME[i]], 1'b0);
      check_idle_outputs("frame1", 0, 1, 14, 0);

      // Mismatch while locked, then reacquire.
      send(8'h5B, 1'b0);
      send(8'h0E, 1'b0);
      check_idle_outputs("lockloss", 0, 0, 15, 1);
      send(8'h5B, 1'b0);
      check_idle_outputs("reacq", 1, 0, 16, 1);

      // Resync at pos 5.
      for (int i = 1; i < 5; i++) send(PATS[FRAME[i]], 1'b0);
      send(8'h5B, 1'b0);
      check_idle_outputs("resync", 1, 0, 21, 2);

      // Unknown / dp patterns in TRACK then HUNT.
      send(8'h8E, 1'b0);
      send(8'h8E, 1'b0);
      send(8'h77, 1'b0);
      send(8'h5B, 1'b0);
      send(8'h77, 1'b0);
      check_idle_outputs("unknown", 0, 0, 22, 4);

      // Random mix of correct glyphs, wrong glyphs and junk.
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 9);
         if (r < 7) send((m_mode == 0) ? PATS[0] : PATS[FRAME[m_pos]], 1'b0);
         else if (r == 7) send(PATS[$urandom_range(0, 7)], 1'b0);
         else if (r == 8) send(8'h80 | 8'($urandom_range(0, 127)), 1'b0);
         else send(8'($urandom_range(0, 255)), 1'b0);
      end

      // Saturation: a repeated S is a mismatch-with-resync every time after the first.
      for (int n = 0; n < 300; n++) send(8'h5B, 1'b0);
      check_idle_outputs("saturate", 1, 0, 255, 255);

      // Lock, then clear coincident with a counting rise.
      for (int i = 1; i < 14; i++) send(PATS[FRAME[i]], 1'b0);
      send(8'h5B, 1'b1);
      check_idle_outputs("clear_rise", 1, 1, 0, 0);
      send(PATS[FRAME[1]], 1'b0);
      send(PATS[FRAME[2]], 1'b0);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      m_mc = 0; m_ec = 0;
      @(negedge clk);
      check_idle_outputs("clear_idle", 3, 1, 0, 0);

      // Reset mid-frame.
      send(PATS[FRAME[3]], 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_idle_outputs("mid_rst", 0, 0, 0, 0);
      chk("mid_rst_char_code", int'(char_code), 0);
      send(8'h5B, 1'b0);

      for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
